decode: RTL and testbench

Second stage of the in-order pipeline, directly downstream of fetch. Consumes `pcD`/`instrD`/`validD`, reads the integer register file, generates immediates and control, and resolves jumps and branches early, returning `PCSrcD`/`pcnD` to fetch. Results are held in a decode→execute pipeline register with stall and flush. The register file lives here and is written by writeback.

---
 rtl/cpu_pkg.sv | 76 +++++++
 rtl/flopr.sv | 18 +
 rtl/regfile.sv | 42 ++++
 rtl/decode.sv | 170 +++++++++++++++++
 tb/tb_decode.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the in-order pipeline.
// Contents: the word width, RV32I opcode and branch funct3 codes, the
// execute-stage ALU select enum, a funct-to-ALU helper, and the
// decode->execute pipeline record.
package cpu_pkg;

    localparam int WORD = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        AND  = 4'd2,
        OR   = 4'd3,
        XOR  = 4'd4,
        SLL  = 4'd5,
        SRL  = 4'd6,
        SRA  = 4'd7,
        SLT  = 4'd8,
        SLTU = 4'd9,
        LUI  = 4'd10,
        LINK = 4'd11
    } alu_ctrl_t;

    typedef struct packed {
        logic [WORD-1:0] pc;
        logic [WORD-1:0] rd1;
        logic [WORD-1:0] rd2;
        logic [WORD-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        alu_ctrl_t       alu_ctrl;
        logic            alu_src;
        logic            reg_write;
        logic            mem_write;
        logic            mem_to_reg;
        logic            valid;
    } de_reg_t;

    // funct3/funct7[5] to ALU select; SUB only exists for register-register ops
    // (OP-IMM with funct3=000 is always ADDI).
    function automatic alu_ctrl_t alu_from_funct(input logic [2:0] f3,
                                                 input logic f7b5,
                                                 input logic is_reg);
        alu_ctrl_t r;
        case (f3)
            3'b000:  r = (is_reg && f7b5) ? SUB : ADD;
            3'b001:  r = SLL;
            3'b010:  r = SLT;
            3'b011:  r = SLTU;
            3'b100:  r = XOR;
            3'b101:  r = f7b5 ? SRA : SRL;
            3'b110:  r = OR;
            default: r = AND;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/flopr.sv
// Resettable enabled register.
// Ports: clk, reset (sync, active-high, clears q), en (load), d, q.
module flopr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/regfile.sv
// Integer register file: two combinational read ports, one write port.
// Ports: clk, reset (sync, clears all registers), we/wa/wd write port,
// ra1/ra2 read addresses, rd1/rd2 read data.
// x0 reads 0; a same-cycle write to the read address is bypassed to the read.
import cpu_pkg::*;

module regfile #(
    parameter int REGS_POWER = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [WORD-1:0] wd,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [WORD-1:0] rd1,
    output logic [WORD-1:0] rd2
);

    logic [WORD-1:0] regs [2**REGS_POWER];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**REGS_POWER; i++) regs[i] <= '0;
        end else if (we && wa != 5'd0) begin
            regs[wa[REGS_POWER-1:0]] <= wd;
        end
    end

    // ra != 0 together with wa == ra already excludes writes to x0.
    always_comb begin
        rd1 = '0;
        if (ra1 != 5'd0) rd1 = (we && wa == ra1) ? wd : regs[ra1[REGS_POWER-1:0]];
    end

    always_comb begin
        rd2 = '0;
        if (ra2 != 5'd0) rd2 = (we && wa == ra2) ? wd : regs[ra2[REGS_POWER-1:0]];
    end

endmodule

// File: rtl/decode.sv
// Decode stage: register-file read, immediate and control generation, early
// jump/branch resolution back to fetch, and the decode->execute register.
// Ports: clk, reset, en (stall when 0), flushE (bubble), pcD/instrD/validD from
// fetch, regWriteW/rdW/resultW writeback port, fwdAD/fwdBD/aluOutM compare
// forwarding, PCSrcD/pcnD redirect, rs1D/rs2D to hazard unit, *E registered
// outputs to execute.
import cpu_pkg::*;

module decode #(
    parameter int REGS_POWER = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            flushE,
    input  logic [WORD-1:0] pcD,
    input  logic [WORD-1:0] instrD,
    input  logic            validD,
    input  logic            regWriteW,
    input  logic [4:0]      rdW,
    input  logic [WORD-1:0] resultW,
    input  logic            fwdAD,
    input  logic            fwdBD,
    input  logic [WORD-1:0] aluOutM,
    output logic            PCSrcD,
    output logic [WORD-1:0] pcnD,
    output logic [4:0]      rs1D,
    output logic [4:0]      rs2D,
    output logic [WORD-1:0] pcE,
    output logic [WORD-1:0] rd1E,
    output logic [WORD-1:0] rd2E,
    output logic [WORD-1:0] immE,
    output logic [4:0]      rs1E,
    output logic [4:0]      rs2E,
    output logic [4:0]      rdE,
    output logic [3:0]      aluCtrlE,
    output logic            aluSrcE,
    output logic            regWriteE,
    output logic            memWriteE,
    output logic            memToRegE,
    output logic            validE
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [WORD-1:0] rd1, rd2, a, b, imm, jalr_sum;
    logic [WORD-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            is_jal, is_jalr, is_branch, taken;
    logic            alu_src, reg_write, mem_write, mem_to_reg;
    alu_ctrl_t       alu_ctrl;
    de_reg_t         dec, de_d, de_q;

    assign opcode = instrD[6:0];
    assign f3     = instrD[14:12];
    assign rs1D   = instrD[19:15];
    assign rs2D   = instrD[24:20];

    assign imm_i = {{20{instrD[31]}}, instrD[31:20]};
    assign imm_s = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
    assign imm_b = {{19{instrD[31]}}, instrD[31], instrD[7], instrD[30:25], instrD[11:8], 1'b0};
    assign imm_u = {instrD[31:12], 12'b0};
    assign imm_j = {{11{instrD[31]}}, instrD[31], instrD[19:12], instrD[20], instrD[30:21], 1'b0};

    regfile #(.REGS_POWER(REGS_POWER)) u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (regWriteW),
        .wa    (rdW),
        .wd    (resultW),
        .ra1   (rs1D),
        .ra2   (rs2D),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    always_comb begin
        imm        = '0;
        alu_ctrl   = ADD;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        is_jal     = 1'b0;
        is_jalr    = 1'b0;
        is_branch  = 1'b0;
        case (opcode)
            OP_LUI:    begin imm = imm_u; alu_ctrl = LUI;  alu_src = 1'b1; reg_write = 1'b1; end
            OP_AUIPC:  begin imm = imm_u; alu_ctrl = ADD;  alu_src = 1'b1; reg_write = 1'b1; end
            OP_JAL:    begin imm = imm_j; alu_ctrl = LINK; reg_write = 1'b1; is_jal = 1'b1; end
            OP_JALR:   begin imm = imm_i; alu_ctrl = LINK; reg_write = 1'b1; is_jalr = 1'b1; end
            OP_BRANCH: begin imm = imm_b; alu_ctrl = SUB;  is_branch = 1'b1; end
            OP_LOAD:   begin
                imm = imm_i; alu_src = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b1;
            end
            OP_STORE:  begin imm = imm_s; alu_src = 1'b1; mem_write = 1'b1; end
            OP_IMM:    begin
                imm = imm_i; alu_src = 1'b1; reg_write = 1'b1;
                alu_ctrl = alu_from_funct(f3, instrD[30], 1'b0);
            end
            OP_OP:     begin
                reg_write = 1'b1;
                alu_ctrl = alu_from_funct(f3, instrD[30], 1'b1);
            end
            default: ;
        endcase
    end

    assign a = fwdAD ? aluOutM : rd1;
    assign b = fwdBD ? aluOutM : rd2;

    always_comb begin
        taken = 1'b0;
        case (f3)
            F3_BEQ:  taken = (a == b);
            F3_BNE:  taken = (a != b);
            F3_BLT:  taken = ($signed(a) <  $signed(b));
            F3_BGE:  taken = ($signed(a) >= $signed(b));
            F3_BLTU: taken = (a <  b);
            F3_BGEU: taken = (a >= b);
            default: taken = 1'b0;
        endcase
    end

    assign jalr_sum = a + imm;
    assign pcnD     = is_jalr ? {jalr_sum[WORD-1:1], 1'b0} : pcD + imm;
    assign PCSrcD   = validD & (is_jal | is_jalr | (is_branch & taken));

    always_comb begin
        dec            = '0;
        dec.pc         = pcD;
        dec.rd1        = rd1;
        dec.rd2        = rd2;
        dec.imm        = imm;
        dec.rs1        = rs1D;
        dec.rs2        = rs2D;
        dec.rd         = instrD[11:7];
        dec.alu_ctrl   = alu_ctrl;
        dec.alu_src    = alu_src;
        dec.reg_write  = reg_write & validD;
        dec.mem_write  = mem_write & validD;
        dec.mem_to_reg = mem_to_reg;
        dec.valid      = validD;
    end

    // Flush loads an all-zero record, so it must also open the enable.
    assign de_d = flushE ? '0 : dec;

    flopr #(.WIDTH($bits(de_reg_t))) u_de_reg (
        .clk   (clk),
        .reset (reset),
        .en    (en | flushE),
        .d     (de_d),
        .q     (de_q)
    );

    assign pcE       = de_q.pc;
    assign rd1E      = de_q.rd1;
    assign rd2E      = de_q.rd2;
    assign immE      = de_q.imm;
    assign rs1E      = de_q.rs1;
    assign rs2E      = de_q.rs2;
    assign rdE       = de_q.rd;
    assign aluCtrlE  = de_q.alu_ctrl;
    assign aluSrcE   = de_q.alu_src;
    assign regWriteE = de_q.reg_write;
    assign memWriteE = de_q.mem_write;
    assign memToRegE = de_q.mem_to_reg;
    assign validE    = de_q.valid;

endmodule

// File: tb/tb_decode.sv
module tb_decode;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, en, flushE, validD, regWriteW, fwdAD, fwdBD;
    logic [31:0] pcD, instrD, resultW, aluOutM;
    logic [4:0]  rdW;
    logic        PCSrcD;
    logic [31:0] pcnD, pcE, rd1E, rd2E, immE;
    logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE;
    logic [3:0]  aluCtrlE;
    logic        aluSrcE, regWriteE, memWriteE, memToRegE, validE;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode dut (
        .clk(clk), .reset(reset), .en(en), .flushE(flushE),
        .pcD(pcD), .instrD(instrD), .validD(validD),
        .regWriteW(regWriteW), .rdW(rdW), .resultW(resultW),
        .fwdAD(fwdAD), .fwdBD(fwdBD), .aluOutM(aluOutM),
        .PCSrcD(PCSrcD), .pcnD(pcnD), .rs1D(rs1D), .rs2D(rs2D),
        .pcE(pcE), .rd1E(rd1E), .rd2E(rd2E), .immE(immE),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .aluCtrlE(aluCtrlE),
        .aluSrcE(aluSrcE), .regWriteE(regWriteE), .memWriteE(memWriteE),
        .memToRegE(memToRegE), .validE(validE)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        fa;
        logic        fb;
        logic [31:0] alum;
        logic        we;
        logic [4:0]  wrd;
        logic [31:0] wd;
        logic        xpcsrc;
        logic [31:0] xpcn;
        logic [31:0] xrd1;
        logic [31:0] xrd2;
        logic [31:0] ximm;
        logic [3:0]  xalu;
        logic        xrw;
        logic        xmw;
        logic        xm2r;
        logic        xv;
    } vec_t;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic        rw;
        logic        mw;
        logic        m2r;
        logic        v;
    } exp_t;

    vec_t vecs[18];
    exp_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic idle_inputs();
        en = 1'b1; flushE = 1'b0; validD = 1'b0; regWriteW = 1'b0;
        fwdAD = 1'b0; fwdBD = 1'b0; pcD = '0; instrD = 32'h0000_0013;
        resultW = '0; aluOutM = '0; rdW = '0;
    endtask

    initial begin
        exp_t e;
        // pc, instr, valid, fa, fb, alum, we, wrd, wd,
        // xpcsrc, xpcn, xrd1, xrd2, ximm, xalu, xrw, xmw, xm2r, xv
        vecs[0]  = '{32'h0,   32'h00128313, 1, 0, 0, 32'h0,   1, 5, 32'h1234,     0, 32'h0,   32'h1234,     32'h0,        32'h1,        ADD,  1, 0, 0, 1};
        vecs[1]  = '{32'h0,   32'h00128313, 1, 0, 0, 32'h0,   1, 1, 32'h7,        0, 32'h0,   32'h1234,     32'h7,        32'h1,        ADD,  1, 0, 0, 1};
        vecs[2]  = '{32'h100, 32'h00208863, 1, 0, 0, 32'h0,   1, 2, 32'h7,        1, 32'h110, 32'h7,        32'h7,        32'h10,       SUB,  0, 0, 0, 1};
        vecs[3]  = '{32'h100, 32'h00208863, 1, 0, 0, 32'h0,   1, 2, 32'h8,        0, 32'h0,   32'h7,        32'h8,        32'h10,       SUB,  0, 0, 0, 1};
        vecs[4]  = '{32'h100, 32'h00209863, 1, 0, 0, 32'h0,   1, 1, 32'hFFFFFFFF, 1, 32'h110, 32'hFFFFFFFF, 32'h8,        32'h10,       SUB,  0, 0, 0, 1};
        vecs[5]  = '{32'h100, 32'h0020E863, 1, 0, 0, 32'h0,   1, 2, 32'h1,        0, 32'h0,   32'hFFFFFFFF, 32'h1,        32'h10,       SUB,  0, 0, 0, 1};
        vecs[6]  = '{32'h100, 32'h0020C863, 1, 0, 0, 32'h0,   0, 0, 32'h0,        1, 32'h110, 32'hFFFFFFFF, 32'h1,        32'h10,       SUB,  0, 0, 0, 1};
        vecs[7]  = '{32'h300, 32'h004180E7, 1, 0, 0, 32'h0,   1, 3, 32'h203,      1, 32'h206, 32'h203,      32'h0,        32'h4,        LINK, 1, 0, 0, 1};
        vecs[8]  = '{32'h300, 32'h004180E7, 1, 1, 0, 32'h400, 0, 0, 32'h0,        1, 32'h404, 32'h203,      32'h0,        32'h4,        LINK, 1, 0, 0, 1};
        vecs[9]  = '{32'h0,   32'h00100313, 1, 0, 0, 32'h0,   1, 0, 32'h55,       0, 32'h0,   32'h0,        32'hFFFFFFFF, 32'h1,        ADD,  1, 0, 0, 1};
        vecs[10] = '{32'h40,  32'h0082A383, 1, 0, 0, 32'h0,   0, 0, 32'h0,        0, 32'h0,   32'h1234,     32'h0,        32'h8,        ADD,  1, 0, 1, 1};
        vecs[11] = '{32'h44,  32'h0062A623, 1, 0, 0, 32'h0,   0, 0, 32'h0,        0, 32'h0,   32'h1234,     32'h0,        32'hC,        ADD,  0, 1, 0, 1};
        vecs[12] = '{32'h48,  32'h12345437, 1, 0, 0, 32'h0,   0, 0, 32'h0,        0, 32'h0,   32'h0,        32'h203,      32'h12345000, LUI,  1, 0, 0, 1};
        vecs[13] = '{32'h200, 32'hFF9FF0EF, 1, 0, 0, 32'h0,   0, 0, 32'h0,        1, 32'h1F8, 32'h0,        32'h0,        32'hFFFFFFF8, LINK, 1, 0, 0, 1};
        vecs[14] = '{32'h4C,  32'h402084B3, 1, 0, 0, 32'h0,   0, 0, 32'h0,        0, 32'h0,   32'hFFFFFFFF, 32'h1,        32'h0,        SUB,  1, 0, 0, 1};
        vecs[15] = '{32'h50,  32'h0000037F, 1, 0, 0, 32'h0,   0, 0, 32'h0,        0, 32'h0,   32'h0,        32'h0,        32'h0,        ADD,  0, 0, 0, 1};
        vecs[16] = '{32'h200, 32'hFF9FF0EF, 0, 0, 0, 32'h0,   0, 0, 32'h0,        0, 32'h0,   32'h0,        32'h0,        32'hFFFFFFF8, LINK, 0, 0, 0, 0};
        vecs[17] = '{32'h100, 32'h00208863, 1, 0, 1, 32'hFFFFFFFF, 0, 0, 32'h0,   1, 32'h110, 32'hFFFFFFFF, 32'h1,        32'h10,       SUB,  0, 0, 0, 1};

        // Reset held two cycles with a valid instruction presented.
        idle_inputs();
        reset = 1'b1; validD = 1'b1; instrD = 32'h00128313; pcD = 32'h80;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_validE", {31'b0, validE}, 32'h0);
        chk("reset_regWriteE", {31'b0, regWriteE}, 32'h0);
        chk("reset_pcE", pcE, 32'h0);
        chk("reset_immE", immE, 32'h0);
        chk("reset_rd1E", rd1E, 32'h0);
        chk("reset_aluCtrlE", {28'b0, aluCtrlE}, 32'h0);
        @(negedge clk);
        reset = 1'b0; validD = 1'b0; instrD = 32'hFF9FF0EF;
        #1;
        chk("invalid_jal_PCSrcD", {31'b0, PCSrcD}, 32'h0);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            pcD = vecs[i].pc; instrD = vecs[i].instr; validD = vecs[i].valid;
            fwdAD = vecs[i].fa; fwdBD = vecs[i].fb; aluOutM = vecs[i].alum;
            regWriteW = vecs[i].we; rdW = vecs[i].wrd; resultW = vecs[i].wd;
            #1;
            chk($sformatf("v%0d_PCSrcD", i), {31'b0, PCSrcD}, {31'b0, vecs[i].xpcsrc});
            if (vecs[i].xpcsrc) chk($sformatf("v%0d_pcnD", i), pcnD, vecs[i].xpcn);
            e.rd1 = vecs[i].xrd1; e.rd2 = vecs[i].xrd2; e.imm = vecs[i].ximm;
            e.alu = vecs[i].xalu; e.rw = vecs[i].xrw; e.mw = vecs[i].xmw;
            e.m2r = vecs[i].xm2r; e.v = vecs[i].xv;
            sbq.push_back(e);
            @(posedge clk);
            #1;
            if (sbq.size() == 0) begin
                chk($sformatf("v%0d_scoreboard_empty", i), 32'h1, 32'h0);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("v%0d_rd1E", i), rd1E, e.rd1);
                chk($sformatf("v%0d_rd2E", i), rd2E, e.rd2);
                chk($sformatf("v%0d_immE", i), immE, e.imm);
                chk($sformatf("v%0d_aluCtrlE", i), {28'b0, aluCtrlE}, {28'b0, e.alu});
                chk($sformatf("v%0d_regWriteE", i), {31'b0, regWriteE}, {31'b0, e.rw});
                chk($sformatf("v%0d_memWriteE", i), {31'b0, memWriteE}, {31'b0, e.mw});
                chk($sformatf("v%0d_memToRegE", i), {31'b0, memToRegE}, {31'b0, e.m2r});
                chk($sformatf("v%0d_validE", i), {31'b0, validE}, {31'b0, e.v});
                chk($sformatf("v%0d_pcE", i), pcE, vecs[i].valid ? vecs[i].pc : vecs[i].pc);
            end
        end

        // Stall: load LUI, then hold for three cycles while decode changes.
        @(negedge clk);
        idle_inputs();
        validD = 1'b1; instrD = 32'h12345437; pcD = 32'h60;
        @(posedge clk); #1;
        chk("stall_load_immE", immE, 32'h12345000);
        @(negedge clk);
        en = 1'b0; instrD = 32'h00128313; pcD = 32'h64;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d_immE", c), immE, 32'h12345000);
            chk($sformatf("stall%0d_pcE", c), pcE, 32'h60);
            chk($sformatf("stall%0d_aluCtrlE", c), {28'b0, aluCtrlE}, {28'b0, LUI});
        end

        // Flush while stalled still bubbles.
        @(negedge clk);
        flushE = 1'b1;
        @(posedge clk); #1;
        chk("flush_stall_validE", {31'b0, validE}, 32'h0);
        chk("flush_stall_regWriteE", {31'b0, regWriteE}, 32'h0);
        chk("flush_stall_immE", immE, 32'h0);

        // Flush with en=1 discards the decoded instruction.
        @(negedge clk);
        flushE = 1'b1; en = 1'b1; instrD = 32'hFF9FF0EF; pcD = 32'h200;
        @(posedge clk); #1;
        chk("flush_en_validE", {31'b0, validE}, 32'h0);
        chk("flush_en_pcE", pcE, 32'h0);

        // Reset during a stall clears the register and the register file.
        @(negedge clk);
        flushE = 1'b0; en = 1'b1; instrD = 32'h00128313; pcD = 32'h70;
        @(posedge clk); #1;
        chk("pre_reset_rd1E", rd1E, 32'h1234);
        @(negedge clk);
        en = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        chk("reset_stall_validE", {31'b0, validE}, 32'h0);
        chk("reset_stall_rd1E", rd1E, 32'h0);
        chk("reset_stall_immE", immE, 32'h0);
        @(negedge clk);
        reset = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_x5_rd1E", rd1E, 32'h0);
        chk("post_reset_immE", immE, 32'h1);
        chk("post_reset_validE", {31'b0, validE}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
